// File: rtl/sdram_wr_pkg.sv
// Shared types and widths for the SDRAM write-path FIFO drain.
package sdram_wr_pkg;

  // Burst length field width; holds 1..256.
  localparam int unsigned WR_LEN_W = 9;

  // Idle-timer width; FLUSH_TIMEOUT must fit below 2**TMR_W.
  localparam int unsigned TMR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_XFER,
    ST_DONE_WAIT
  } state_e;

endpackage

// File: rtl/sdram_fifo_wr_drain_if.sv
// Burst request/data bus between the FIFO drain (master) and the SDRAM core (slave).
interface sdram_fifo_wr_drain_if
  import sdram_wr_pkg::*;
#(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 32
);
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WR_LEN_W-1:0] wr_len;
  logic                wr_ack;
  logic                wr_data_req;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_done;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_len,
    output wr_data,
    input  wr_ack,
    input  wr_data_req,
    input  wr_done
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_len,
    input  wr_data,
    output wr_ack,
    output wr_data_req,
    output wr_done
  );
endinterface

// File: rtl/sdram_burst_buf.sv
// One-burst staging register file: indexed write port, registered indexed read port.
module sdram_burst_buf #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset; only words below the fill count are ever read.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Read register doubles as the beat output, so it clears on reset and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n)  rd_data <= '0;
    else if (re) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/sdram_fifo_wr_drain.sv
// Drains the write-path FIFO into a staging buffer and issues SDRAM write bursts
// over a self-advancing ring of word addresses.
module sdram_fifo_wr_drain
  import sdram_wr_pkg::*;
#(
  parameter int unsigned BURST_LEN     = 8,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 22,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned END_ADDR      = 32'h003F_FFFF,
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  output logic                 fifo_rd_en,
  input  logic [DATA_W-1:0]    fifo_rd_data,
  input  logic                 fifo_empty,
  sdram_fifo_wr_drain_if.master wr_bus,
  output logic                 busy,
  output logic                 addr_wrap
);

  localparam int unsigned          AX_W   = ADDR_W + 1;
  localparam int unsigned          BUF_AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [AX_W-1:0]      END_X  = AX_W'(END_ADDR);
  localparam logic [AX_W-1:0]      BL_X   = AX_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]    BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [WR_LEN_W-1:0]  BL_L   = WR_LEN_W'(BURST_LEN);
  localparam logic [WR_LEN_W-1:0]  ONE_L  = WR_LEN_W'(1);
  localparam logic [TMR_W-1:0]     TMO    = TMR_W'(FLUSH_TIMEOUT);

  state_e              state;
  logic [WR_LEN_W-1:0] count;
  logic [WR_LEN_W-1:0] idx;
  logic [WR_LEN_W-1:0] target;
  logic                pending;
  logic                flush_q;
  logic [TMR_W-1:0]    timer;
  logic [ADDR_W-1:0]   cur_addr;
  logic [AX_W-1:0]     room;
  logic [AX_W-1:0]     next_addr;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WR_LEN_W-1:0] len_q;
  logic [DATA_W-1:0]   beat_q;
  logic                buf_re;
  logic                fill_done;
  logic                fill_cut;

  // Burst size is clipped so a burst never runs past the end of the ring.
  assign room      = END_X - {1'b0, cur_addr} + AX_W'(1);
  assign target    = (room < BL_X) ? room[WR_LEN_W-1:0] : BL_L;
  assign next_addr = {1'b0, cur_addr} + AX_W'(len_q);

  assign fifo_rd_en = (state == ST_FILL) && !fifo_empty && enable &&
                      ((count + WR_LEN_W'(pending)) < target);
  assign fill_done  = (count == target);
  assign fill_cut   = (count != '0) && !pending &&
                      (flush || flush_q || !enable || (timer == TMO));
  assign buf_re     = (state == ST_XFER) && wr_bus.wr_data_req;

  assign busy           = (state != ST_IDLE);
  assign wr_bus.wr_req  = req_q;
  assign wr_bus.wr_addr = addr_q;
  assign wr_bus.wr_len  = len_q;
  assign wr_bus.wr_data = beat_q;

  sdram_burst_buf #(
    .DEPTH  (BURST_LEN),
    .DATA_W (DATA_W),
    .IDX_W  (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (pending),
    .wr_idx  (count[BUF_AW-1:0]),
    .wr_data (fifo_rd_data),
    .re      (buf_re),
    .rd_idx  (idx[BUF_AW-1:0]),
    .rd_data (beat_q)
  );

  // Burst FSM with fill counter, idle timer, held flush and ring address generator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      flush_q   <= 1'b0;
      timer     <= '0;
      cur_addr  <= BASE_A;
      req_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      addr_wrap <= 1'b0;
    end else begin
      addr_wrap <= 1'b0;
      pending   <= fifo_rd_en;
      if (pending) count <= count + ONE_L;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_FILL;
        end
        ST_FILL: begin
          if (fifo_rd_en)                       timer <= '0;
          else if (count != '0 && timer != TMO) timer <= timer + TMR_W'(1);
          if (flush && pending) flush_q <= 1'b1;
          if (fill_done || fill_cut) begin
            state   <= ST_REQ;
            req_q   <= 1'b1;
            addr_q  <= cur_addr;
            len_q   <= count;
            timer   <= '0;
            flush_q <= 1'b0;
          end else if (count == '0 && !pending && !enable) begin
            state   <= ST_IDLE;
            timer   <= '0;
            flush_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (wr_bus.wr_ack) begin
            state <= ST_XFER;
            req_q <= 1'b0;
            idx   <= '0;
          end
        end
        ST_XFER: begin
          if (wr_bus.wr_data_req) begin
            idx <= idx + ONE_L;
            if (idx + ONE_L == len_q) state <= ST_DONE_WAIT;
          end
        end
        ST_DONE_WAIT: begin
          if (wr_bus.wr_done) begin
            if (next_addr > END_X) begin
              cur_addr  <= BASE_A;
              addr_wrap <= 1'b1;
            end else begin
              cur_addr  <= next_addr[ADDR_W-1:0];
            end
            count <= '0;
            idx   <= '0;
            state <= enable ? ST_FILL : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_fifo_wr_drain.sv
// Directed bench for sdram_fifo_wr_drain: a FIFO model feeds two instances
// (open ring and a 12-word ring) and a scripted core checks every burst.
module tb_sdram_fifo_wr_drain;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        wr_ack;
  logic        wr_data_req;
  logic        wr_done;
  logic        sel;
  logic        fifo_clr;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
  logic        rd_en_a, rd_en_b, busy_a, busy_b, wrap_a, wrap_b;

  logic [31:0] fmem [256];
  int          wr_ptr;
  int          rd_ptr;

  int n_vec;
  int n_err;
  int w;

  logic        rq, bsy, wrp, rden;
  logic [21:0] ra;
  logic [8:0]  rl;
  logic [31:0] rd;

  sdram_fifo_wr_drain_if #(.ADDR_W(22), .DATA_W(32)) bus_a ();
  sdram_fifo_wr_drain_if #(.ADDR_W(22), .DATA_W(32)) bus_b ();

  assign bus_a.wr_ack      = wr_ack;
  assign bus_a.wr_data_req = wr_data_req;
  assign bus_a.wr_done     = wr_done;
  assign bus_b.wr_ack      = wr_ack;
  assign bus_b.wr_data_req = wr_data_req;
  assign bus_b.wr_done     = wr_done;

  sdram_fifo_wr_drain #(
    .BURST_LEN(8), .DATA_W(32), .ADDR_W(22),
    .BASE_ADDR(0), .END_ADDR(32'h003F_FFFF), .FLUSH_TIMEOUT(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable & ~sel), .flush(flush),
    .fifo_rd_en(rd_en_a), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .wr_bus(bus_a), .busy(busy_a), .addr_wrap(wrap_a)
  );

  sdram_fifo_wr_drain #(
    .BURST_LEN(8), .DATA_W(32), .ADDR_W(22),
    .BASE_ADDR(0), .END_ADDR(11), .FLUSH_TIMEOUT(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable & sel), .flush(flush),
    .fifo_rd_en(rd_en_b), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .wr_bus(bus_b), .busy(busy_b), .addr_wrap(wrap_b)
  );

  assign rq   = sel ? bus_b.wr_req  : bus_a.wr_req;
  assign ra   = sel ? bus_b.wr_addr : bus_a.wr_addr;
  assign rl   = sel ? bus_b.wr_len  : bus_a.wr_len;
  assign rd   = sel ? bus_b.wr_data : bus_a.wr_data;
  assign bsy  = sel ? busy_b : busy_a;
  assign wrp  = sel ? wrap_b : wrap_a;
  assign rden = sel ? rd_en_b : rd_en_a;

  assign fifo_empty = (rd_ptr == wr_ptr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read side: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (rden) begin
      fifo_rd_data <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = first + 32'(i);
      wr_ptr++;
    end
  endtask

  task automatic wait_req(input int limit, output int waited);
    waited = 0;
    while (!rq && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic do_burst(input string tag, input int exp_addr, input int exp_len,
                          input logic [31:0] first, input int ack_dly, input bit gapped,
                          input bit extra, input bit exp_wrap);
    int wt;
    wait_req(200, wt);
    chk({tag, ".req"}, 64'(rq), 64'd1);
    chk({tag, ".addr"}, 64'(ra), 64'(exp_addr));
    chk({tag, ".len"}, 64'(rl), 64'(exp_len));
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      chk({tag, ".hold_req"}, 64'(rq), 64'd1);
      chk({tag, ".hold_addr"}, 64'(ra), 64'(exp_addr));
      chk({tag, ".hold_len"}, 64'(rl), 64'(exp_len));
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk({tag, ".req_drop"}, 64'(rq), 64'd0);
    for (int i = 0; i < exp_len; i++) begin
      if (gapped) repeat ((i * 3) % 4) @(negedge clk);
      wr_data_req = 1'b1;
      @(negedge clk);
      wr_data_req = 1'b0;
      chk({tag, ".beat"}, 64'(rd), 64'(first + 32'(i)));
    end
    if (extra) begin
      wr_data_req = 1'b1;
      @(negedge clk);
      wr_data_req = 1'b0;
      chk({tag, ".extra_hold"}, 64'(rd), 64'(first + 32'(exp_len - 1)));
    end
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    chk({tag, ".wrap"}, 64'(wrp), 64'(exp_wrap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; wr_ptr = 0; rd_ptr = 0;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; sel = 1'b0; fifo_clr = 1'b0;
    wr_ack = 1'b0; wr_data_req = 1'b0; wr_done = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst.req", 64'(rq), 64'd0);
    chk("rst.addr", 64'(ra), 64'd0);
    chk("rst.len", 64'(rl), 64'd0);
    chk("rst.data", 64'(rd), 64'd0);
    chk("rst.busy", 64'(bsy), 64'd0);
    chk("rst.wrap", 64'(wrp), 64'd0);
    chk("rst.rden", 64'(rden), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.busy", 64'(bsy), 64'd0);

    // Full bursts from a preloaded FIFO
    push(32'h100, 16);
    enable = 1'b1;
    wait_req(50, w);
    chk("full.latency", 64'(w), 64'd11);
    chk("full.busy", 64'(bsy), 64'd1);
    do_burst("full1", 0, 8, 32'h100, 0, 1'b0, 1'b0, 1'b0);
    do_burst("full2", 8, 8, 32'h108, 0, 1'b0, 1'b0, 1'b0);

    // Partial burst after the idle timeout
    push(32'h200, 3);
    wait_req(60, w);
    chk("tmo.latency", 64'(w), 64'd20);
    do_burst("tmo", 16, 3, 32'h200, 0, 1'b0, 1'b0, 1'b0);

    // Manual flush of five words
    push(32'h300, 5);
    repeat (8) @(negedge clk);
    chk("flush.noreq", 64'(rq), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_req(5, w);
    chk("flush.latency", 64'(w), 64'd0);
    do_burst("flush", 19, 5, 32'h300, 0, 1'b0, 1'b0, 1'b0);

    // Late ack, gapped beats, surplus beat request
    push(32'h400, 8);
    do_burst("hs", 24, 8, 32'h400, 10, 1'b1, 1'b1, 1'b0);

    // Flush arriving while the last word is still in flight
    push(32'h500, 2);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_req(40, w);
    chk("hflush.latency", 64'(w), 64'd1);
    do_burst("hflush", 32, 2, 32'h500, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a transfer
    push(32'h600, 8);
    wait_req(40, w);
    chk("mid.addr", 64'(ra), 64'd34);
    chk("mid.len", 64'(rl), 64'd8);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data_req = 1'b1;
      @(negedge clk);
      wr_data_req = 1'b0;
      chk("mid.beat", 64'(rd), 64'(32'h600 + 32'(i)));
    end
    rst_n = 1'b0; enable = 1'b0; fifo_clr = 1'b1;
    @(negedge clk);
    chk("mrst.req", 64'(rq), 64'd0);
    chk("mrst.addr", 64'(ra), 64'd0);
    chk("mrst.len", 64'(rl), 64'd0);
    chk("mrst.data", 64'(rd), 64'd0);
    chk("mrst.busy", 64'(bsy), 64'd0);
    chk("mrst.rden", 64'(rden), 64'd0);
    fifo_clr = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    push(32'h700, 8);
    enable = 1'b1;
    do_burst("post_rst", 0, 8, 32'h700, 0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst.idle", 64'(bsy), 64'd0);

    // Ring wrap on the 12-word instance
    sel = 1'b1;
    push(32'h800, 24);
    enable = 1'b1;
    do_burst("wrap1", 0, 8, 32'h800, 0, 1'b0, 1'b0, 1'b0);
    do_burst("wrap2", 8, 4, 32'h808, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap2.pulse_end", 64'(wrp), 64'd0);
    do_burst("wrap3", 0, 8, 32'h80C, 0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
